// File: rtl/ram_cmd_arbiter.sv
// Two-requester command arbiter in front of a single-port RAM: round-robin grant,
// ownership lock across address/data phases, read-response routing and timeouts.
module ram_cmd_arbiter #(
  parameter int RD_TIMEOUT   = 64,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [9:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [9:0] req1_data,
  output logic       req1_ready,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_data,
  output logic       timeout_err,
  output logic       busy
);
  localparam int MAX_TO = (RD_TIMEOUT > LOCK_TIMEOUT) ? RD_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW     = (MAX_TO < 2) ? 1 : $clog2(MAX_TO + 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_RD} state_t;
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] payload;
  } cmd_t;

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          acc0, acc1, accept;
  cmd_t          acc_cmd;

  // In IDLE a lone valid requester wins; on contention the one not granted last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & (~req1_valid | last_grant);
        req1_ready = req1_valid & (~req0_valid | ~last_grant);
      end
      LOCKED: begin
        req0_ready = ~owner;
        req1_ready = owner;
      end
      default: ;
    endcase
  end

  assign acc0    = req0_valid & req0_ready;
  assign acc1    = req1_valid & req1_ready;
  assign accept  = acc0 | acc1;
  assign acc_cmd = acc1 ? req1_data : req0_data;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_data     <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      ram_rx_valid <= accept;
      if (accept) ram_din <= acc_cmd;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            last_grant <= acc1;
            case (acc_cmd.op)
              OP_WR_ADDR, OP_RD_ADDR: begin owner <= acc1; state <= LOCKED;  end
              OP_RD_DATA:             begin owner <= acc1; state <= WAIT_RD; end
              default: ;
            endcase
          end
        end
        LOCKED: begin
          if (accept) begin
            cnt <= '0;
            case (acc_cmd.op)
              OP_WR_DATA: state <= IDLE;
              OP_RD_DATA: state <= WAIT_RD;
              default: ;
            endcase
          end else if (cnt == LOCK_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RD: begin
          // A response arriving on the final allowed cycle beats the timeout.
          if (ram_tx_valid) begin
            rsp_data   <= ram_dout;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= IDLE;
            cnt        <= '0;
          end else if (cnt == RD_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: timestamp-based phase model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ram_cmd_arbiter;
  localparam int RD_TO   = 64;
  localparam int LOCK_TO = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [9:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = '0;
  logic       ram_tx_valid = 1'b0;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_data;
  logic       timeout_err, busy;

  int checks = 0;
  int errs   = 0;

  ram_cmd_arbiter #(.RD_TIMEOUT(RD_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=locked 2=waiting for read data; time spent in a phase
  // is measured from the cycle stamp at which the phase (or lock window) began.
  int         cyc = 0;
  int         ph = 0;
  int         enter = 0;
  bit         own = 1'b0, lst = 1'b1;
  logic [9:0] e_din = '0;
  logic [7:0] e_rd = '0;
  bit         e_rxv = 1'b0, e_r0 = 1'b0, e_r1 = 1'b0, e_terr = 1'b0;

  function automatic logic [1:0] exp_ready();
    if (ph == 0) begin
      if (req0_valid && req1_valid) return lst ? 2'b01 : 2'b10;
      return {req1_valid, req0_valid};
    end
    if (ph == 1) return own ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step();
    logic [1:0] rd;
    logic [9:0] d;
    bit         a0, a1, acc;
    int         spent;
    if (!rst_n) begin
      ph = 0; own = 1'b0; lst = 1'b1;
      e_din = '0; e_rd = '0; e_rxv = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_terr = 1'b0;
      return;
    end
    rd    = exp_ready();
    a0    = req0_valid && rd[0];
    a1    = req1_valid && rd[1];
    acc   = a0 || a1;
    d     = a1 ? req1_data : req0_data;
    spent = cyc - enter + 1;
    e_rxv = acc;
    if (acc) e_din = d;
    e_r0 = 1'b0; e_r1 = 1'b0; e_terr = 1'b0;
    case (ph)
      0: if (acc) begin
        lst = a1;
        if (d[9:8] != 2'b01) begin
          own = a1; ph = (d[9:8] == 2'b11) ? 2 : 1; enter = cyc + 1;
        end
      end
      1: if (acc) begin
        if (d[9:8] == 2'b01) ph = 0;
        else begin
          if (d[9:8] == 2'b11) ph = 2;
          enter = cyc + 1;
        end
      end else if (spent >= LOCK_TO) begin
        ph = 0; e_terr = 1'b1;
      end
      default: if (ram_tx_valid) begin
        e_rd = ram_dout; e_r0 = !own; e_r1 = own; ph = 0;
      end else if (spent >= RD_TO) begin
        ph = 0; e_terr = 1'b1;
      end
    endcase
    cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    logic [1:0] r;
    @(negedge clk);
    r = exp_ready();
    chk("cmp_req0_ready", 32'(req0_ready), 32'(r[0]));
    chk("cmp_req1_ready", 32'(req1_ready), 32'(r[1]));
    chk("cmp_ram_din", 32'(ram_din), 32'(e_din));
    chk("cmp_ram_rx_valid", 32'(ram_rx_valid), 32'(e_rxv));
    chk("cmp_rsp0_valid", 32'(rsp0_valid), 32'(e_r0));
    chk("cmp_rsp1_valid", 32'(rsp1_valid), 32'(e_r1));
    chk("cmp_timeout_err", 32'(timeout_err), 32'(e_terr));
    chk("cmp_busy", 32'(busy), 32'(ph != 0));
    if (e_r0 || e_r1) chk("cmp_rsp_data", 32'(rsp_data), 32'(e_rd));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until timeout_err is seen; an expired budget shows up as a bad count.
  task automatic wait_timeout(output int n);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (timeout_err) break;
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_din", 32'(ram_din), 32'(0));
    chk("rst_rx_valid", 32'(ram_rx_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_timeout", 32'(timeout_err), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Simultaneous wr-addr: req0 wins after reset, then lock blocks req1.
    req0_valid = 1'b1; req0_data = 10'h0A5;
    req1_valid = 1'b1; req1_data = 10'h0A5;
    @(negedge clk);
    chk("arb_req0_ready", 32'(req0_ready), 32'(1));
    chk("arb_req1_ready", 32'(req1_ready), 32'(0));
    tick(); req0_data = 10'h13C;
    @(negedge clk);
    chk("fwd_ram_din", 32'(ram_din), 32'h0A5);
    chk("fwd_rx_valid", 32'(ram_rx_valid), 32'(1));
    chk("lock_busy", 32'(busy), 32'(1));
    chk("lock_req1_blocked", 32'(req1_ready), 32'(0));
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("wrdata_ram_din", 32'(ram_din), 32'h13C);
    chk("wrdata_idle", 32'(busy), 32'(0));
    chk("rr_req1_ready", 32'(req1_ready), 32'(1));

    // req1: 0x0A5 accepted, then 0x210, 0x300, read data three cycles later.
    tick(); req1_data = 10'h210;
    tick(); req1_data = 10'h300;
    tick(); req1_valid = 1'b0;
    tick();
    tick(); ram_tx_valid = 1'b1; ram_dout = 8'h5E;
    tick(); ram_tx_valid = 1'b0;
    @(negedge clk);
    chk("rsp1_strobe", 32'(rsp1_valid), 32'(1));
    chk("rsp1_data", 32'(rsp_data), 32'h5E);
    chk("rsp0_quiet", 32'(rsp0_valid), 32'(0));
    tick();
    @(negedge clk);
    chk("rsp1_one_cycle", 32'(rsp1_valid), 32'(0));

    // Stray RAM data in IDLE must be ignored.
    ram_tx_valid = 1'b1; ram_dout = 8'h11;
    tick(); ram_tx_valid = 1'b0;
    @(negedge clk);
    chk("stray_rsp0", 32'(rsp0_valid), 32'(0));
    chk("stray_rsp1", 32'(rsp1_valid), 32'(0));
    chk("stray_busy", 32'(busy), 32'(0));

    // Read timeout with req1 pending.
    tick();
    req0_valid = 1'b1; req0_data = 10'h300;
    req1_valid = 1'b1; req1_data = 10'h080;
    @(negedge clk);
    chk("rdto_req0_wins", 32'(req0_ready), 32'(1));
    tick(); req0_valid = 1'b0;
    wait_timeout(n);
    chk("rdto_cycles", 32'(n), 32'(64));
    chk("rdto_no_rsp", 32'(rsp0_valid), 32'(0));
    chk("rdto_req1_served", 32'(req1_ready), 32'(1));
    tick(); req1_data = 10'h13C;
    tick(); req1_valid = 1'b0;

    // Lock timeout with req1 pending.
    req0_valid = 1'b1; req0_data = 10'h080;
    tick(); req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 10'h1AA;
    wait_timeout(n);
    chk("lockto_cycles", 32'(n), 32'(255));
    chk("lockto_busy", 32'(busy), 32'(0));
    chk("lockto_req1_ready", 32'(req1_ready), 32'(1));
    tick(); req1_valid = 1'b0;
    @(negedge clk);
    chk("lockto_fwd_din", 32'(ram_din), 32'h1AA);
    chk("lockto_fwd_rxv", 32'(ram_rx_valid), 32'(1));

    // Read data on the last allowed cycle wins over the timeout.
    tick(); req0_valid = 1'b1; req0_data = 10'h300;
    tick(); req0_valid = 1'b0;
    repeat (63) tick();
    ram_tx_valid = 1'b1; ram_dout = 8'h77;
    tick(); ram_tx_valid = 1'b0;
    @(negedge clk);
    chk("edge_rsp0", 32'(rsp0_valid), 32'(1));
    chk("edge_rsp_data", 32'(rsp_data), 32'h77);
    chk("edge_no_timeout", 32'(timeout_err), 32'(0));

    // Owner command on the last allowed lock cycle keeps the lock.
    tick(); req0_valid = 1'b1; req0_data = 10'h080;
    tick(); req0_valid = 1'b0;
    repeat (254) tick();
    req0_valid = 1'b1; req0_data = 10'h000;
    tick(); req0_data = 10'h140;
    @(negedge clk);
    chk("lockedge_no_timeout", 32'(timeout_err), 32'(0));
    chk("lockedge_busy", 32'(busy), 32'(1));
    chk("lockedge_din", 32'(ram_din), 32'h000);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("lockedge_release", 32'(busy), 32'(0));

    // Reset during WAIT_RD abandons the read.
    tick(); req0_valid = 1'b1; req0_data = 10'h300;
    tick(); req0_valid = 1'b0;
    tick();
    tick(); rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_din", 32'(ram_din), 32'(0));
    chk("midrst_rxv", 32'(ram_rx_valid), 32'(0));
    chk("midrst_rsp0", 32'(rsp0_valid), 32'(0));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    ram_tx_valid = 1'b1; ram_dout = 8'h99;
    tick(); ram_tx_valid = 1'b0;
    @(negedge clk);
    chk("postrst_rsp0", 32'(rsp0_valid), 32'(0));
    chk("postrst_rsp1", 32'(rsp1_valid), 32'(0));
    chk("postrst_busy", 32'(busy), 32'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_cmd_arbiter.md
RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 Parameter RD_TIMEOUT, default 64: max cycles waited in WAIT_RD for ram_tx_valid.
REQ-002 Parameter LOCK_TIMEOUT, default 255: max idle cycles in LOCKED before ownership is revoked.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester command valid.
REQ-006 req0_data, req1_data  input  10 each  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-007 req0_ready, req1_ready  output  1 each  command accepted this cycle when valid&ready.
REQ-008 ram_din  output  10  command forwarded to RAM.
REQ-009 ram_rx_valid  output  1  one-cycle strobe qualifying ram_din.
REQ-010 ram_dout  input  8  RAM read data.
REQ-011 ram_tx_valid  input  1  RAM read data valid.
REQ-012 rsp0_valid, rsp1_valid  output  1 each  one-cycle read-response strobe to the owning requester.
REQ-013 rsp_data  output  8  read data, shared by both requesters; valid only with rspN_valid.
REQ-014 timeout_err  output  1  one-cycle pulse on any RD or LOCK timeout.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, LOCKED, WAIT_RD; owner register (1 bit); last_grant register (1 bit); one shared timeout counter.
REQ-017 IDLE: ready goes to exactly one valid requester. With both valid, the requester other than last_grant wins. With one valid, that requester wins.
REQ-018 reqN_ready is combinational from state, owner, last_grant and the valids. readyN never depends on readyM.
REQ-019 Accept: ram_din <= accepted data and ram_rx_valid <= 1 on the next edge (latency 1). Otherwise ram_rx_valid = 0 and ram_din holds its value.
REQ-020 IDLE accept, opcode 00/10: owner <= winner, last_grant <= winner, go to LOCKED.
REQ-021 IDLE accept, opcode 01: last_grant <= winner, stay IDLE.
REQ-022 IDLE accept, opcode 11: owner <= winner, last_grant <= winner, go to WAIT_RD.
REQ-023 LOCKED: only the owner is ready; the non-owner's ready = 0 regardless of valid.
REQ-024 LOCKED accept, opcode 00/10: forward the command, stay LOCKED, clear the counter.
REQ-025 LOCKED accept, opcode 01: forward the command, go to IDLE.
REQ-026 LOCKED accept, opcode 11: forward the command, go to WAIT_RD.
REQ-027 LOCKED: the counter increments each cycle with no accept. On reaching LOCK_TIMEOUT: go to IDLE, pulse timeout_err, forward nothing.
REQ-028 WAIT_RD: both readys = 0. The counter increments each cycle.
REQ-029 WAIT_RD with ram_tx_valid: next edge rsp_data <= ram_dout, rsp<owner>_valid <= 1 (one cycle), go to IDLE.
REQ-030 WAIT_RD, counter reaching RD_TIMEOUT without ram_tx_valid: go to IDLE, pulse timeout_err, no rsp strobe.
REQ-031 If ram_tx_valid arrives in the same cycle the counter hits RD_TIMEOUT, the response wins and timeout_err stays 0.
REQ-032 ram_tx_valid outside WAIT_RD is ignored: no rsp strobe, no state change.
REQ-033 The counter clears on every state transition and is wide enough for max(RD_TIMEOUT, LOCK_TIMEOUT) without wrap.
REQ-034 A requester dropping valid while not accepted has no effect. Data is sampled only on the accept cycle.

Reset
REQ-035 While rst_n = 0, immediately (asynchronously):
  - state = IDLE, owner = 0, last_grant = 1, counter = 0.
  - ram_din = 0, ram_rx_valid = 0, rsp_data = 0, rsp0_valid = rsp1_valid = 0, timeout_err = 0, busy = 0.
REQ-036 Reset mid-transaction (LOCKED or WAIT_RD) abandons it; no strobe is emitted afterward for the abandoned command.

Verification
REQ-037 After reset, req0 and req1 both send 0x0A5 (wr-addr A5) in the same cycle -> req0 accepted; next cycle ram_din = 0x0A5 with ram_rx_valid = 1; busy = 1.
REQ-038 Continuing REQ-037: req1 holds 0x0A5 while req0 sends 0x13C -> req1_ready = 0 throughout; 0x13C forwarded; IDLE; req1 then accepted (round-robin).
REQ-039 req1 sends 0x210 then 0x300; RAM returns ram_tx_valid with ram_dout = 0x5E three cycles later -> rsp1_valid pulses once with rsp_data = 0x5E; rsp0_valid stays 0.
REQ-040 req0 sends 0x300; ram_tx_valid is never asserted -> timeout_err pulses after RD_TIMEOUT cycles; IDLE; no rsp strobe; req1 is then served.
REQ-041 req0 sends 0x080, then goes silent -> after LOCK_TIMEOUT cycles timeout_err pulses, busy = 0, and a pending req1 command is accepted the next cycle.
REQ-042 rst_n asserted during WAIT_RD, then ram_tx_valid pulses after reset release -> all outputs at reset values; no rsp strobe.
